ps2_key_disp_ctrl: RTL and testbench
====================================

Name: ps2_key_disp_ctrl

Overview:
Sequences the PS/2 keyboard byte stream into the stable, registered key state consumed by the eight-digit seven-segment decoder.
- Outputs: current scan code, press count, shift/ctrl flags, display enable.
- Decodes E0/F0 prefixes and suppresses typematic repeats.
- Recovers from truncated sequences via a prefix timeout.
- Sits between the PS/2 receiver FIFO and the segment decoder.

Parameters:
CNT_W, 8, width of press counter (wraps).
TIMEOUT_CYC, 1000000, cycles allowed between a prefix byte and its following byte before abandoning the sequence.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
rx_valid  input  1  receiver has a byte available
rx_data  input  8  received scan byte
rx_ready  output  1  byte consumed this cycle when rx_valid && rx_ready
scan_code  output  8  last non-modifier make code latched
count  output  CNT_W  number of distinct non-modifier presses
is_shift  output  1  left (0x12) or right (0x59) shift held
is_ctrl  output  1  left (0x14) or right (E0 14) ctrl held
is_ext  output  1  latched scan_code came with E0 prefix
disp_en  output  1  a non-modifier key is currently held (decoder blanks when 0)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. No other clocks or resets.
- Reset values:
  - rx_ready = 0 while rst is high; = 1 otherwise (combinational ~rst).
  - scan_code = 0x00, count = 0, is_shift = is_ctrl = is_ext = disp_en = 0.
  - State = IDLE; internal held-code register = 0x00, held_valid = 0.
- Reset mid-sequence: reset abandons any partial prefix. No partial update of any output.
- Accept: a byte is taken every cycle rx_valid is high (no backpressure outside reset). Outputs are registered and update the cycle after acceptance (latency 1).
- FSM states: IDLE, EXT, BRK, EXT_BRK.
  - IDLE: E0 -> EXT; F0 -> BRK; other byte -> MAKE(code, ext=0), stay IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> stay EXT; other -> MAKE(code, ext=1), then IDLE.
  - BRK: E0 -> EXT_BRK (tolerated ordering); F0 -> stay BRK; other -> BREAK(code, ext=0), then IDLE.
  - EXT_BRK: prefix bytes -> stay; other -> BREAK(code, ext=1), then IDLE.
- MAKE(c, e):
  - c = 0x12 or 0x59: set the corresponding shift bit.
  - c = 0x14: set lctrl (e=0) or rctrl (e=1).
  - Modifier makes never touch scan_code, count, is_ext or disp_en.
  - Non-modifier, held_valid && held == {e,c} (typematic repeat): no change.
  - Non-modifier otherwise: scan_code <= c, is_ext <= e, held <= {e,c}, held_valid <= 1, disp_en <= 1, count <= count + 1 (modulo 2^CNT_W, 0xFF -> 0x00).
- BREAK(c, e):
  - Modifier: clear the corresponding bit.
  - Non-modifier matching held: held_valid <= 0, disp_en <= 0. scan_code, is_ext and count keep their values.
  - Non-matching non-modifier break (key rolled over): ignored.
- Timeout:
  - In EXT, BRK or EXT_BRK, the idle-cycle counter increments each cycle with no accepted byte.
  - Counter reaches TIMEOUT_CYC -> return to IDLE, no output change.
  - Counter clears on any accept and in IDLE.
  - An accept on the same cycle as expiry wins: the byte is processed in the current state.
- is_shift = lshift | rshift; is_ctrl = lctrl | rctrl; both registered.
- Byte 0x00 or 0xFF (error/overrun codes) in any state: discarded, state -> IDLE.

Decomposition:
- Package ps2_pkg:
  - Byte constants: PS2_BRK = 0xF0, PS2_EXT = 0xE0, PS2_LSHIFT = 0x12, PS2_RSHIFT = 0x59, PS2_CTRL = 0x14, PS2_ERR0 = 0x00, PS2_ERR1 = 0xFF.
  - FSM state enum.
- One sub-module: ps2_prefix_timer.
  - Ports: clk, rst, clear, run; output expired.
  - Counter width is $clog2(TIMEOUT_CYC+1).

Test Plan:
- Bytes 1C, F0 1C after reset -> scan_code=1C, count=1, disp_en=1 after first byte; disp_en=0 after F0 1C; scan_code stays 1C.
- 1C ×5 (typematic), then F0 1C -> count=1 throughout, disp_en falls only after the break.
- 12, 1C, F0 12, F0 1C -> is_shift=1 from cycle after 12 until after F0 12; scan_code=1C, count=1; the 12 never appears on scan_code.
- E0 14, E0 75, E0 F0 75, E0 F0 14 -> is_ctrl=1, scan_code=75, is_ext=1, count=1; ctrl and disp_en clear on their breaks.
- Preload count=0xFF via 255 distinct press/release pairs, one more press -> count=0x00.
- Timeout and reset: F0 then idle TIMEOUT_CYC cycles, then 1C -> treated as make (count+1, disp_en=1); rst asserted after E0 -> all outputs 0, next 75 gives is_ext=0.

Source files
------------

// File: rtl/ps2_key_disp_ctrl_pkg.sv
// ps2_pkg
// Shared definitions for the PS/2 key display controller:
//   - scan-byte constants for prefixes, modifiers and receiver error codes
//   - the prefix-decoder FSM state type
//   - small byte classification helpers
// No ports; imported by the controller top.
package ps2_pkg;

    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_LSHIFT = 8'h12;
    localparam logic [7:0] PS2_RSHIFT = 8'h59;
    localparam logic [7:0] PS2_CTRL   = 8'h14;
    localparam logic [7:0] PS2_ERR0   = 8'h00;
    localparam logic [7:0] PS2_ERR1   = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } ps2_state_e;

    // Prefix bytes only steer the decoder; they never carry a key code.
    function automatic logic isPrefix(input logic [7:0] b);
        return (b == PS2_BRK) || (b == PS2_EXT);
    endfunction

    // Receiver error / overrun codes are thrown away and resync the decoder.
    function automatic logic isErr(input logic [7:0] b);
        return (b == PS2_ERR0) || (b == PS2_ERR1);
    endfunction

endpackage

// File: rtl/ps2_key_disp_ctrl_if.sv
// ps2_key_disp_ctrl_if
// Bundles the byte stream from the PS/2 receiver FIFO and the registered key
// state handed to the seven-segment decoder.
//   rx_valid  : receiver has a byte available        (byte source -> controller)
//   rx_data   : received scan byte                   (byte source -> controller)
//   rx_ready  : byte consumed when rx_valid&&rx_ready (controller -> source)
//   scan_code : last non-modifier make code latched
//   count     : number of distinct non-modifier presses (wraps)
//   is_shift  : either shift key held
//   is_ctrl   : either ctrl key held
//   is_ext    : latched scan_code carried an E0 prefix
//   disp_en   : a non-modifier key is currently held
// Modports: master = byte source / display consumer, slave = controller.
interface ps2_key_disp_ctrl_if #(
    parameter int CNT_W = 8
) ();

    logic             rx_valid;
    logic [7:0]       rx_data;
    logic             rx_ready;
    logic [7:0]       scan_code;
    logic [CNT_W-1:0] count;
    logic             is_shift;
    logic             is_ctrl;
    logic             is_ext;
    logic             disp_en;

    modport master (
        output rx_valid,
        output rx_data,
        input  rx_ready,
        input  scan_code,
        input  count,
        input  is_shift,
        input  is_ctrl,
        input  is_ext,
        input  disp_en
    );

    modport slave (
        input  rx_valid,
        input  rx_data,
        output rx_ready,
        output scan_code,
        output count,
        output is_shift,
        output is_ctrl,
        output is_ext,
        output disp_en
    );

endinterface

// File: rtl/ps2_key_disp_ctrl_prefix_timer.sv
// ps2_prefix_timer
// Counts idle cycles while the decoder waits for the byte following a prefix
// and flags when the wait has lasted TIMEOUT_CYC cycles.
//   clk     : system clock
//   rst     : synchronous reset, active-high
//   clear   : restart the count (a byte was accepted, or decoder is idle)
//   run     : a prefix is pending and no byte arrived this cycle
//   expired : this idle cycle is the TIMEOUT_CYC-th; abandon the sequence
module ps2_prefix_timer #(
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int             CW   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0]  LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] r_idleCnt;

    // The counter lands on TIMEOUT_CYC on the same edge the decoder drops
    // back to idle; from then on the decoder sits in idle and clear holds
    // the count at zero, so it never runs past TIMEOUT_CYC.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_idleCnt <= '0;
        end else if (run) begin
            r_idleCnt <= r_idleCnt + CW'(1);
        end
    end

    assign expired = run && (r_idleCnt == LAST);

endmodule

// File: rtl/ps2_key_disp_ctrl.sv
// ps2_key_disp_ctrl
// Turns the PS/2 scan byte stream into stable key state for the eight-digit
// seven-segment decoder: decodes E0/F0 prefixes, tracks shift/ctrl, filters
// typematic repeats, counts distinct presses and recovers from truncated
// prefix sequences through an idle timeout.
//   clk : system clock
//   rst : synchronous reset, active-high
//   bus : slave side of ps2_key_disp_ctrl_if (byte input + key state output)
module ps2_key_disp_ctrl
    import ps2_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                 clk,
    input  logic                 rst,
    ps2_key_disp_ctrl_if.slave   bus
);

    ps2_state_e       r_state;
    logic [7:0]       r_scanCode;
    logic [CNT_W-1:0] r_count;
    logic             r_lshift;
    logic             r_rshift;
    logic             r_lctrl;
    logic             r_rctrl;
    logic             r_isShift;
    logic             r_isCtrl;
    logic             r_isExt;
    logic             r_dispEn;
    logic [8:0]       r_held;
    logic             r_heldValid;

    logic       w_accept;
    logic [7:0] w_byte;
    logic       w_evtMake;
    logic       w_evtBreak;
    logic       w_evtExt;
    logic       w_isLShift;
    logic       w_isRShift;
    logic       w_isCtrlCode;
    logic       w_isMod;
    logic       w_matchHeld;
    logic       w_lshiftNext;
    logic       w_rshiftNext;
    logic       w_lctrlNext;
    logic       w_rctrlNext;
    logic       w_timerRun;
    logic       w_timerClear;
    logic       w_expired;

    // No backpressure: everything offered outside reset is taken.
    assign w_accept = bus.rx_valid && !rst;
    assign w_byte   = bus.rx_data;

    assign w_isLShift   = (w_byte == PS2_LSHIFT);
    assign w_isRShift   = (w_byte == PS2_RSHIFT);
    assign w_isCtrlCode = (w_byte == PS2_CTRL);
    assign w_isMod      = w_isLShift || w_isRShift || w_isCtrlCode;
    assign w_matchHeld  = r_heldValid && (r_held == {w_evtExt, w_byte});

    // A code byte (not a prefix, not an error) completes a make or break
    // event whose flavour and E0 qualifier come from the state it lands in.
    always_comb begin
        w_evtMake  = 1'b0;
        w_evtBreak = 1'b0;
        w_evtExt   = 1'b0;
        if (w_accept && !isErr(w_byte) && !isPrefix(w_byte)) begin
            case (r_state)
                ST_IDLE:    w_evtMake  = 1'b1;
                ST_EXT:     begin w_evtMake  = 1'b1; w_evtExt = 1'b1; end
                ST_BRK:     w_evtBreak = 1'b1;
                ST_EXT_BRK: begin w_evtBreak = 1'b1; w_evtExt = 1'b1; end
                default:    w_evtMake  = 1'b0;
            endcase
        end
    end

    // Modifier bits are kept per physical key so releasing one shift or
    // ctrl does not drop the other; shift ignores E0, ctrl uses it to pick
    // the left or right key.
    always_comb begin
        w_lshiftNext = r_lshift;
        w_rshiftNext = r_rshift;
        w_lctrlNext  = r_lctrl;
        w_rctrlNext  = r_rctrl;
        if (w_evtMake || w_evtBreak) begin
            if (w_isLShift) w_lshiftNext = w_evtMake;
            if (w_isRShift) w_rshiftNext = w_evtMake;
            if (w_isCtrlCode && !w_evtExt) w_lctrlNext = w_evtMake;
            if (w_isCtrlCode &&  w_evtExt) w_rctrlNext = w_evtMake;
        end
    end

    // The timer only runs while a prefix is outstanding and nothing arrived;
    // an accept on the expiry cycle therefore suppresses expiry entirely.
    assign w_timerRun   = (r_state != ST_IDLE) && !w_accept;
    assign w_timerClear = w_accept || (r_state == ST_IDLE);

    ps2_prefix_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_timerClear),
        .run     (w_timerRun),
        .expired (w_expired)
    );

    // Prefix decoder state plus all registered key outputs. A repeat of the
    // held key (typematic) changes nothing; a break only releases the display
    // if it names the held key, so rolled-over keys are ignored. Error bytes
    // and timeouts resync to idle without touching any output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_scanCode  <= 8'h00;
            r_count     <= '0;
            r_lshift    <= 1'b0;
            r_rshift    <= 1'b0;
            r_lctrl     <= 1'b0;
            r_rctrl     <= 1'b0;
            r_isShift   <= 1'b0;
            r_isCtrl    <= 1'b0;
            r_isExt     <= 1'b0;
            r_dispEn    <= 1'b0;
            r_held      <= 9'h000;
            r_heldValid <= 1'b0;
        end else begin
            r_lshift  <= w_lshiftNext;
            r_rshift  <= w_rshiftNext;
            r_lctrl   <= w_lctrlNext;
            r_rctrl   <= w_rctrlNext;
            r_isShift <= w_lshiftNext || w_rshiftNext;
            r_isCtrl  <= w_lctrlNext || w_rctrlNext;

            if (w_evtMake && !w_isMod && !w_matchHeld) begin
                r_scanCode  <= w_byte;
                r_isExt     <= w_evtExt;
                r_held      <= {w_evtExt, w_byte};
                r_heldValid <= 1'b1;
                r_dispEn    <= 1'b1;
                r_count     <= r_count + CNT_W'(1);
            end

            if (w_evtBreak && !w_isMod && w_matchHeld) begin
                r_heldValid <= 1'b0;
                r_dispEn    <= 1'b0;
            end

            if (w_accept) begin
                if (isErr(w_byte)) begin
                    r_state <= ST_IDLE;
                end else begin
                    case (r_state)
                        ST_IDLE: begin
                            if (w_byte == PS2_EXT)      r_state <= ST_EXT;
                            else if (w_byte == PS2_BRK) r_state <= ST_BRK;
                            else                        r_state <= ST_IDLE;
                        end
                        ST_EXT: begin
                            if (w_byte == PS2_BRK)      r_state <= ST_EXT_BRK;
                            else if (w_byte == PS2_EXT) r_state <= ST_EXT;
                            else                        r_state <= ST_IDLE;
                        end
                        ST_BRK: begin
                            if (w_byte == PS2_EXT)      r_state <= ST_EXT_BRK;
                            else if (w_byte == PS2_BRK) r_state <= ST_BRK;
                            else                        r_state <= ST_IDLE;
                        end
                        ST_EXT_BRK: begin
                            if (isPrefix(w_byte))       r_state <= ST_EXT_BRK;
                            else                        r_state <= ST_IDLE;
                        end
                        default:                        r_state <= ST_IDLE;
                    endcase
                end
            end else if (w_expired) begin
                r_state <= ST_IDLE;
            end
        end
    end

    assign bus.rx_ready  = ~rst;
    assign bus.scan_code = r_scanCode;
    assign bus.count     = r_count;
    assign bus.is_shift  = r_isShift;
    assign bus.is_ctrl   = r_isCtrl;
    assign bus.is_ext    = r_isExt;
    assign bus.disp_en   = r_dispEn;

endmodule

// File: tb/tb_ps2_key_disp_ctrl.sv
// tb_ps2_key_disp_ctrl
// Directed byte sequences with hand-computed key state after each byte.
// Each issued byte pushes its expected state into a queue; a monitor pops
// and compares on the falling edge after every accepted byte.
module tb_ps2_key_disp_ctrl;

    localparam int CNT_W = 8;
    localparam int TO    = 16;

    typedef struct packed {
        logic [7:0] scan;
        logic [7:0] cnt;
        logic       sh;
        logic       ct;
        logic       ext;
        logic       en;
    } snap_t;

    logic clk = 1'b0;
    logic rst;

    snap_t expQ[$];
    string nameQ[$];
    int    checks = 0;
    int    errors = 0;
    logic  monAcc;

    always #5 clk = ~clk;

    ps2_key_disp_ctrl_if #(.CNT_W(CNT_W)) bus ();

    ps2_key_disp_ctrl #(
        .CNT_W       (CNT_W),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Compare the full visible key state against one expected snapshot.
    task automatic checkOutput(input string name, input snap_t exp);
        snap_t act;
        act = {bus.scan_code, bus.count, bus.is_shift, bus.is_ctrl, bus.is_ext, bus.disp_en};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got scan=%h cnt=%h sh=%b ct=%b ext=%b en=%b, want scan=%h cnt=%h sh=%b ct=%b ext=%b en=%b",
                     name, act.scan, act.cnt, act.sh, act.ct, act.ext, act.en,
                     exp.scan, exp.cnt, exp.sh, exp.ct, exp.ext, exp.en);
        end
    endtask

    task automatic checkReady(input string name, input logic exp);
        checks++;
        if (bus.rx_ready !== exp) begin
            errors++;
            $display("[TB] FAIL %s: rx_ready got %b want %b", name, bus.rx_ready, exp);
        end
    endtask

    // Offer one byte for a single cycle; fl = {is_shift, is_ctrl, is_ext, disp_en}.
    task automatic applyStimulus(input string name, input logic [7:0] b,
                                 input logic [7:0] scan, input logic [7:0] cnt,
                                 input logic [3:0] fl);
        expQ.push_back({scan, cnt, fl});
        nameQ.push_back(name);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard monitor: an accept seen at a rising edge means the
    // registered outputs are valid by the following falling edge.
    initial begin
        forever begin
            @(posedge clk);
            monAcc = bus.rx_valid && bus.rx_ready;
            @(negedge clk);
            if (monAcc) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_accept: got accept with empty queue, want none");
                end else begin
                    checkOutput(nameQ.pop_front(), expQ.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no completion, want finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        idleCycles(3);
        checkOutput("reset_state", '0);
        checkReady("ready_in_reset", 1'b0);
        rst = 1'b0;
        idleCycles(1);
        checkReady("ready_after_reset", 1'b1);

        // Plain make then break.
        applyStimulus("mk1C",      8'h1C, 8'h1C, 8'd1, 4'b0001);
        applyStimulus("pfx_F0",    8'hF0, 8'h1C, 8'd1, 4'b0001);
        applyStimulus("brk1C",     8'h1C, 8'h1C, 8'd1, 4'b0000);

        // Typematic repeats do not count.
        applyStimulus("mk1C_b",    8'h1C, 8'h1C, 8'd2, 4'b0001);
        for (int i = 0; i < 4; i++)
            applyStimulus("rep1C", 8'h1C, 8'h1C, 8'd2, 4'b0001);
        applyStimulus("pfx_F0_b",  8'hF0, 8'h1C, 8'd2, 4'b0001);
        applyStimulus("brk1C_b",   8'h1C, 8'h1C, 8'd2, 4'b0000);

        // Left shift around a key press; 12 never reaches scan_code.
        applyStimulus("mk12",      8'h12, 8'h1C, 8'd2, 4'b1000);
        applyStimulus("mk1C_sh",   8'h1C, 8'h1C, 8'd3, 4'b1001);
        applyStimulus("pfx_F0_c",  8'hF0, 8'h1C, 8'd3, 4'b1001);
        applyStimulus("brk12",     8'h12, 8'h1C, 8'd3, 4'b0001);
        applyStimulus("pfx_F0_d",  8'hF0, 8'h1C, 8'd3, 4'b0001);
        applyStimulus("brk1C_c",   8'h1C, 8'h1C, 8'd3, 4'b0000);

        // Right ctrl (E0 14) and extended key E0 75.
        applyStimulus("pfx_E0",    8'hE0, 8'h1C, 8'd3, 4'b0000);
        applyStimulus("mkRctrl",   8'h14, 8'h1C, 8'd3, 4'b0100);
        applyStimulus("pfx_E0_b",  8'hE0, 8'h1C, 8'd3, 4'b0100);
        applyStimulus("mkE075",    8'h75, 8'h75, 8'd4, 4'b0111);
        applyStimulus("pfx_E0_c",  8'hE0, 8'h75, 8'd4, 4'b0111);
        applyStimulus("pfx_F0_e",  8'hF0, 8'h75, 8'd4, 4'b0111);
        applyStimulus("brkE075",   8'h75, 8'h75, 8'd4, 4'b0110);
        applyStimulus("pfx_E0_d",  8'hE0, 8'h75, 8'd4, 4'b0110);
        applyStimulus("pfx_F0_f",  8'hF0, 8'h75, 8'd4, 4'b0110);
        applyStimulus("brkRctrl",  8'h14, 8'h75, 8'd4, 4'b0010);

        // Error byte drops the E0 prefix; F0 E0 ordering is an extended break.
        applyStimulus("pfx_E0_e",  8'hE0, 8'h75, 8'd4, 4'b0010);
        applyStimulus("errFF",     8'hFF, 8'h75, 8'd4, 4'b0010);
        applyStimulus("mk75",      8'h75, 8'h75, 8'd5, 4'b0001);
        applyStimulus("pfx_F0_g",  8'hF0, 8'h75, 8'd5, 4'b0001);
        applyStimulus("pfx_E0_f",  8'hE0, 8'h75, 8'd5, 4'b0001);
        applyStimulus("brkE075_nm",8'h75, 8'h75, 8'd5, 4'b0001);
        applyStimulus("pfx_F0_h",  8'hF0, 8'h75, 8'd5, 4'b0001);
        applyStimulus("brk75",     8'h75, 8'h75, 8'd5, 4'b0000);

        // Right shift and left ctrl; an E0 14 break must not clear left ctrl.
        applyStimulus("mk59",      8'h59, 8'h75, 8'd5, 4'b1000);
        applyStimulus("mkLctrl",   8'h14, 8'h75, 8'd5, 4'b1100);
        applyStimulus("pfx_F0_i",  8'hF0, 8'h75, 8'd5, 4'b1100);
        applyStimulus("brk59",     8'h59, 8'h75, 8'd5, 4'b0100);
        applyStimulus("pfx_E0_g",  8'hE0, 8'h75, 8'd5, 4'b0100);
        applyStimulus("pfx_F0_j",  8'hF0, 8'h75, 8'd5, 4'b0100);
        applyStimulus("brkRctrl_b",8'h14, 8'h75, 8'd5, 4'b0100);
        applyStimulus("pfx_F0_k",  8'hF0, 8'h75, 8'd5, 4'b0100);
        applyStimulus("brkLctrl",  8'h14, 8'h75, 8'd5, 4'b0000);

        // Press/release pairs from count 5 up through 0xFF and wrap to 0x00.
        for (int i = 0; i <= 250; i++) begin
            logic [7:0] c;
            c = 8'(6 + i);
            applyStimulus("wrap_mk",  8'h1C, 8'h1C, c, 4'b0001);
            applyStimulus("wrap_pfx", 8'hF0, 8'h1C, c, 4'b0001);
            applyStimulus("wrap_brk", 8'h1C, 8'h1C, c, 4'b0000);
        end

        // Break prefix still pending just before the timeout.
        applyStimulus("to_mk1C",   8'h1C, 8'h1C, 8'd1, 4'b0001);
        applyStimulus("to_pfx",    8'hF0, 8'h1C, 8'd1, 4'b0001);
        idleCycles(TO - 2);
        applyStimulus("to_brk",    8'h1C, 8'h1C, 8'd1, 4'b0000);

        // Break prefix abandoned after the timeout; 1C is then a make.
        applyStimulus("to_pfx_b",  8'hF0, 8'h1C, 8'd1, 4'b0000);
        idleCycles(TO + 4);
        applyStimulus("to_mk_b",   8'h1C, 8'h1C, 8'd2, 4'b0001);
        applyStimulus("to_pfx_c",  8'hF0, 8'h1C, 8'd2, 4'b0001);
        applyStimulus("to_brk_b",  8'h1C, 8'h1C, 8'd2, 4'b0000);

        // Extended prefix abandoned after the timeout.
        applyStimulus("to_pfx_e0", 8'hE0, 8'h1C, 8'd2, 4'b0000);
        idleCycles(TO + 4);
        applyStimulus("to_mk75",   8'h75, 8'h75, 8'd3, 4'b0001);

        // Reset in the middle of an E0 sequence.
        applyStimulus("rs_pfx",    8'hE0, 8'h75, 8'd3, 4'b0001);
        rst = 1'b1;
        idleCycles(2);
        checkOutput("reset_mid_seq", '0);
        checkReady("ready_mid_reset", 1'b0);
        rst = 1'b0;
        applyStimulus("rs_mk75",   8'h75, 8'h75, 8'd1, 4'b0001);

        for (int i = 0; i < 10 && expQ.size() != 0; i++)
            @(negedge clk);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending expectations, want 0", expQ.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
